// File: rtl/hamming_decoder_pipe.sv
// Streaming Hamming(7,4) single-error-correcting decoder with a 2-stage valid/ready pipeline.
// Optional saturating statistics counters are compiled in with `define HAMMING_DEC_STATS_EN.
module hamming_decoder_pipe #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_codeword,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_message,
  output logic             out_corrected,
  output logic [2:0]       out_err_pos
`ifdef HAMMING_DEC_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_words,
  output logic [CNT_W-1:0] stat_corrected
`endif
);

  function automatic logic [2:0] syndrome_of(input logic [6:0] cw);
    logic s1, s2, s4;
    s1 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    s2 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    s4 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    return {s4, s2, s1};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic       adv1, adv2;
  logic       vld_p1_q, vld_p1_d;
  logic [6:0] cw_p1_q, cw_p1_d;
  logic [2:0] syn_p1_q, syn_p1_d;
  logic       vld_p2_q, vld_p2_d;
  logic [3:0] msg_p2_q, msg_p2_d;
  logic       corr_p2_q, corr_p2_d;
  logic [2:0] pos_p2_q, pos_p2_d;
  logic [7:0] flip_mask;
  logic [6:0] fixed_cw;

  always_comb begin
    adv2 = !vld_p2_q || out_ready;
    adv1 = !vld_p1_q || adv2;

    // Stage 1: capture codeword and syndrome
    vld_p1_d = vld_p1_q;
    cw_p1_d  = cw_p1_q;
    syn_p1_d = syn_p1_q;
    if (adv1) begin
      vld_p1_d = in_valid;
      if (in_valid) begin
        cw_p1_d  = in_codeword;
        syn_p1_d = syndrome_of(in_codeword);
      end
    end

    // Stage 2: correct and extract; syndrome 0 shifts the flip bit out of the used range
    flip_mask = 8'b1 << syn_p1_q;
    fixed_cw  = cw_p1_q ^ flip_mask[7:1];
    vld_p2_d  = vld_p2_q;
    msg_p2_d  = msg_p2_q;
    corr_p2_d = corr_p2_q;
    pos_p2_d  = pos_p2_q;
    if (adv2) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        msg_p2_d  = {fixed_cw[6], fixed_cw[5], fixed_cw[4], fixed_cw[2]};
        corr_p2_d = (syn_p1_q != 3'd0);
        pos_p2_d  = syn_p1_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      msg_p2_q  <= '0;
      corr_p2_q <= 1'b0;
      pos_p2_q  <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      msg_p2_q  <= msg_p2_d;
      corr_p2_q <= corr_p2_d;
      pos_p2_q  <= pos_p2_d;
    end
  end

  // Stage-1 data may hold stale values while invalid, so it carries no reset
  always_ff @(posedge clk) begin
    cw_p1_q  <= cw_p1_d;
    syn_p1_q <= syn_p1_d;
  end

  assign in_ready      = adv1;
  assign out_valid     = vld_p2_q;
  assign out_message   = msg_p2_q;
  assign out_corrected = corr_p2_q;
  assign out_err_pos   = pos_p2_q;

`ifdef HAMMING_DEC_STATS_EN
  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;

  always_comb begin
    words_d    = words_q;
    corr_cnt_d = corr_cnt_q;
    if (stat_clr) begin
      words_d    = '0;
      corr_cnt_d = '0;
    end else if (vld_p2_q && out_ready) begin
      words_d = sat_inc(words_q);
      if (corr_p2_q) corr_cnt_d = sat_inc(corr_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q    <= '0;
      corr_cnt_q <= '0;
    end else begin
      words_q    <= words_d;
      corr_cnt_q <= corr_cnt_d;
    end
  end

  assign stat_words     = words_q;
  assign stat_corrected = corr_cnt_q;
`endif

endmodule
